// File: rtl/tx_pkg.sv
// tx_pkg: shared widths, FSM states and slot descriptor for the TX redundancy buffer
package tx_pkg;
    localparam int TAG_MAX_W = 32;
    localparam int LEN_MAX_W = 24;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_STREAM} rd_state_t;
    typedef struct packed {
        logic                 valid;
        logic                 filling;
        logic [TAG_MAX_W-1:0] tag;
        logic [LEN_MAX_W-1:0] len;
    } slot_t;
    function automatic int slot_w(input int n);
        return $clog2(n);
    endfunction
    function automatic int addr_w(input int n, input int depth);
        return $clog2(n) + $clog2(depth);
    endfunction
endpackage

// File: rtl/tx_slot_ram.sv
// tx_slot_ram: simple dual-port word store with a registered, resettable read port
module tx_slot_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    // write port
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // registered read port, cleared by reset so the output starts at zero
    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/tx_redundancy_buffer.sv
// tx_redundancy_buffer: captures first transmissions into tagged slots and replays them until the last copy
module tx_redundancy_buffer
    import tx_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int SEG_BYTES_MAX = 1024,
    parameter int NUM_SLOTS     = 4,
    parameter int SEGNUM_W      = 16,
    parameter int TXID_W        = 8
) (
    input  logic                       i_clk125MHz,
    input  logic                       i_rstn,
    input  logic [TXID_W-1:0]          i_redundancy,
    input  logic                       i_wr_start,
    input  logic [SEGNUM_W-1:0]        i_wr_segnum,
    input  logic                       i_wr_valid,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_wr_last,
    output logic                       o_wr_ready,
    input  logic                       i_rd_start,
    input  logic [SEGNUM_W-1:0]        i_rd_segnum,
    input  logic [TXID_W-1:0]          i_rd_txid,
    output logic                       o_rd_valid,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic                       o_rd_last,
    output logic                       o_rd_miss,
    output logic [$clog2(NUM_SLOTS):0] o_free_slots,
    output logic                       o_err_trunc
);
    localparam int SLOT_W = slot_w(NUM_SLOTS);
    localparam int OFF_W  = $clog2(SEG_BYTES_MAX);
    localparam int CNT_W  = $clog2(SEG_BYTES_MAX + 1);
    localparam int ADDR_W = addr_w(NUM_SLOTS, SEG_BYTES_MAX);
    localparam int FREE_W = $clog2(NUM_SLOTS) + 1;

    wr_state_t           r_wst, w_wst_nxt;
    rd_state_t           r_rst, w_rst_nxt;
    slot_t               r_slot [NUM_SLOTS];
    logic [SLOT_W-1:0]   r_wr_slot, r_rd_slot, w_free_idx, w_hit_idx;
    logic [CNT_W-1:0]    r_wr_off, r_rd_off, r_rd_len;
    logic [SEGNUM_W-1:0] r_rd_tag;
    logic [TXID_W-1:0]   r_rd_txid, r_rd_red;
    logic [FREE_W-1:0]   w_free_cnt;
    logic                r_trunc_seen, r_err_trunc, r_rd_valid, r_rd_last, r_rd_miss;
    logic                w_any_free, w_hit, w_alloc, w_full, w_we, w_re, w_rd_end, w_release;

    // lowest free slot, free count and tag lookup among committed slots
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_free_cnt = '0;
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slot[i].valid && !r_slot[i].filling) begin
                w_any_free = 1'b1;
                w_free_idx = SLOT_W'(i);
                w_free_cnt = w_free_cnt + FREE_W'(1);
            end
            if (r_slot[i].valid && !r_slot[i].filling && r_slot[i].tag == TAG_MAX_W'(r_rd_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = SLOT_W'(i);
            end
        end
    end

    // state registers of both FSMs
    always_ff @(posedge i_clk125MHz) begin
        if (!i_rstn) begin
            r_wst <= W_IDLE;
            r_rst <= R_IDLE;
        end else begin
            r_wst <= w_wst_nxt;
            r_rst <= w_rst_nxt;
        end
    end

    // write FSM next state
    always_comb begin
        w_wst_nxt = W_IDLE;
        case (r_wst)
            W_IDLE:  w_wst_nxt = (i_wr_start && w_any_free) ? W_FILL : W_IDLE;
            W_FILL:  w_wst_nxt = (i_wr_valid && i_wr_last) ? W_COMMIT : W_FILL;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    // write FSM outputs: allocation, RAM write enable, ready
    always_comb begin
        w_alloc    = r_wst == W_IDLE && i_wr_start && w_any_free;
        w_full     = r_wr_off == CNT_W'(SEG_BYTES_MAX);
        w_we       = r_wst == W_FILL && i_wr_valid && !w_full;
        o_wr_ready = (r_wst == W_IDLE && w_any_free) || r_wst == W_FILL;
    end

    // read FSM next state
    always_comb begin
        w_rst_nxt = R_IDLE;
        case (r_rst)
            R_IDLE:   w_rst_nxt = i_rd_start ? R_LOOKUP : R_IDLE;
            R_LOOKUP: w_rst_nxt = w_hit ? R_STREAM : R_IDLE;
            default:  w_rst_nxt = w_rd_end ? R_IDLE : R_STREAM;
        endcase
    end

    // read FSM outputs: RAM read, end of stream, slot release on the final copy
    always_comb begin
        w_re      = r_rst == R_STREAM && r_rd_len != '0;
        w_rd_end  = r_rst == R_STREAM && (r_rd_len == '0 || r_rd_off == r_rd_len - CNT_W'(1));
        w_release = w_rd_end && r_rd_txid >= r_rd_red;
    end

    // slot table: allocate, commit with newest-wins dedupe, release
    always_ff @(posedge i_clk125MHz) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!i_rstn) begin
                r_slot[i] <= '0;
            end else begin
                if (w_alloc && w_free_idx == SLOT_W'(i)) begin
                    r_slot[i].filling <= 1'b1;
                    r_slot[i].tag     <= TAG_MAX_W'(i_wr_segnum);
                end
                if (r_wst == W_COMMIT && r_wr_slot == SLOT_W'(i)) begin
                    r_slot[i].valid   <= 1'b1;
                    r_slot[i].filling <= 1'b0;
                    r_slot[i].len     <= LEN_MAX_W'(r_wr_off);
                end else if (r_wst == W_COMMIT && r_slot[i].valid && r_slot[i].tag == r_slot[r_wr_slot].tag) begin
                    r_slot[i].valid <= 1'b0;
                end
                if (w_release && r_rd_slot == SLOT_W'(i)) r_slot[i].valid <= 1'b0;
            end
        end
    end

    // capture and replay datapath registers
    always_ff @(posedge i_clk125MHz) begin
        if (!i_rstn) begin
            r_wr_slot    <= '0;
            r_wr_off     <= '0;
            r_trunc_seen <= 1'b0;
            r_err_trunc  <= 1'b0;
            r_rd_tag     <= '0;
            r_rd_txid    <= '0;
            r_rd_red     <= '0;
            r_rd_slot    <= '0;
            r_rd_off     <= '0;
            r_rd_len     <= '0;
            r_rd_miss    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_wr_slot    <= w_free_idx;
                r_wr_off     <= '0;
                r_trunc_seen <= 1'b0;
            end else if (w_we) begin
                r_wr_off <= r_wr_off + CNT_W'(1);
            end else if (r_wst == W_FILL && i_wr_valid) begin
                r_trunc_seen <= 1'b1;
            end
            r_err_trunc <= r_wst == W_FILL && i_wr_valid && w_full && !r_trunc_seen;
            if (r_rst == R_IDLE && i_rd_start) begin
                r_rd_tag  <= i_rd_segnum;
                r_rd_txid <= i_rd_txid;
                r_rd_red  <= i_redundancy;
            end
            if (r_rst == R_LOOKUP) begin
                r_rd_slot <= w_hit_idx;
                r_rd_off  <= '0;
                r_rd_len  <= CNT_W'(r_slot[w_hit_idx].len);
            end else if (w_re) begin
                r_rd_off <= r_rd_off + CNT_W'(1);
            end
            r_rd_miss  <= r_rst == R_LOOKUP && !w_hit;
            r_rd_valid <= w_re;
            r_rd_last  <= w_re && w_rd_end;
        end
    end

    tx_slot_ram #(
        .DATA_W(DATA_W),
        .DEPTH (1 << ADDR_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .i_clk  (i_clk125MHz),
        .i_rstn (i_rstn),
        .i_we   (w_we),
        .i_waddr({r_wr_slot, r_wr_off[OFF_W-1:0]}),
        .i_wdata(i_wr_data),
        .i_re   (w_re),
        .i_raddr({r_rd_slot, r_rd_off[OFF_W-1:0]}),
        .o_rdata(o_rd_data)
    );

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_last    = r_rd_last;
    assign o_rd_miss    = r_rd_miss;
    assign o_err_trunc  = r_err_trunc;
    assign o_free_slots = w_free_cnt;
endmodule

// File: doc/tx_redundancy_buffer.md
Name: tx_redundancy_buffer

Overview:
Parametrised successor to the per-segment replay storage in the TX path. It captures the byte stream of each segment's first transmission (txid==1) into one of NUM_SLOTS slots in a shared RAM, tagged by segment number. It then replays a slot on request for txid 2..redundancy. The slot is released after the final copy (txid==redundancy), so storage scales with in-flight segments rather than with SEGMENT_NUMBER_MAX.

Parameters:
DATA_W, 8, width of the payload word.
SEG_BYTES_MAX, 1024, maximum words per segment; excess words are dropped.
NUM_SLOTS, 4, number of concurrently stored segments (power of 2, 2..16).
SEGNUM_W, 16, width of the segment-number tag.
TXID_W, 8, width of the txid and redundancy fields.

Ports:
clk125MHz  in  1  Ethernet TX clock; the only clock.
rstn  in  1  synchronous active-low reset.
redundancy  in  TXID_W  total copies per segment (>=1); sampled at rd_start.
wr_start  in  1  pulse that opens a capture; wr_segnum is latched.
wr_segnum  in  SEGNUM_W  tag of the segment being captured.
wr_valid  in  1  wr_data qualifier.
wr_data  in  DATA_W  first-transmission word.
wr_last  in  1  marks the final word, qualified by wr_valid.
wr_ready  out  1  high while W_IDLE with a free slot, or in W_FILL.
rd_start  in  1  pulse that requests a replay.
rd_segnum  in  SEGNUM_W  tag to replay.
rd_txid  in  TXID_W  copy index of this replay (2..redundancy).
rd_valid  out  1  rd_data qualifier.
rd_data  out  DATA_W  replayed word.
rd_last  out  1  final word of the replay.
rd_miss  out  1  1-cycle pulse: the tag was not found.
free_slots  out  clog2(NUM_SLOTS)+1  number of unallocated slots.
err_trunc  out  1  1-cycle pulse: a capture exceeded SEG_BYTES_MAX.

Behaviour:
- Reset (rstn==0 at the clock edge): all slots invalid and free; both FSMs idle. Reset values: rd_valid/rd_last/rd_miss/err_trunc=0, rd_data=0, free_slots=NUM_SLOTS, wr_ready=1. Reset mid-capture or mid-replay aborts the operation; no partial slot survives.
- RAM: one simple dual-port array of NUM_SLOTS*SEG_BYTES_MAX words with 1-cycle registered read. Address = {slot, offset}.
- Per-slot state: valid, filling, tag, len (words stored).
- Write FSM:
  - W_IDLE: on wr_start with free_slots>0, allocate the lowest-index free slot, set filling, latch the tag, offset=0, go to W_FILL. wr_start with no free slot is ignored (wr_ready=0).
  - W_FILL: each wr_valid writes a word at offset, then offset++. Words arriving at offset==SEG_BYTES_MAX are not written, and err_trunc pulses once per capture. wr_valid&&wr_last → W_COMMIT.
  - W_COMMIT (1 cycle): len=offset (count of words written), valid=1, filling=0. Any other valid slot with an equal tag is invalidated and freed in the same cycle; the newest capture wins. → W_IDLE.
- Read FSM:
  - R_IDLE: rd_start latches rd_segnum, rd_txid and redundancy → R_LOOKUP. rd_start in any other state is ignored.
  - R_LOOKUP (1 cycle): parallel tag compare against valid, non-filling slots. No hit → rd_miss pulse, → R_IDLE. Hit → R_STREAM with offset=0.
  - R_STREAM: issue one read per cycle. rd_valid is asserted 1 cycle after each read (RAM latency). The first rd_valid comes 3 cycles after rd_start. len words are output back to back, and rd_last goes with word len-1. A len==0 slot outputs nothing and goes directly to release.
  - After the last word: if latched rd_txid>=latched redundancy, free the slot. → R_IDLE.
- Simultaneous allocate (W_IDLE) and release (R_STREAM end) in one cycle: free_slots = old - 1 + 1. A released slot becomes allocatable on the next cycle, not the same cycle.
- free_slots is updated in the cycle after allocation/release and never underflows or overflows.
- The RAM is read and written in the same cycle only at different slots, because a filling slot is never a lookup hit.

Decomposition:
- Shared package tx_pkg: ADDR_W/SLOT_W functions (clog2), FSM state enums (W_IDLE/W_FILL/W_COMMIT, R_IDLE/R_LOOKUP/R_STREAM), slot-descriptor struct {valid, filling, tag, len}.
- One sub-module: tx_slot_ram. Simple dual-port, 1-cycle registered read, inferrable as block RAM, parametrised DATA_W/depth.

Test Plan:
- Capture segnum=5, 16 words 0x00..0x0F, redundancy=3. Replay txid=2 → rd_valid 3 cycles after rd_start, data 0x00..0x0F, rd_last on 0x0F, free_slots=3. Replay txid=3 → same data, then free_slots=4.
- NUM_SLOTS=4: capture segnums 1..4 → free_slots=0, wr_ready=0. Extra wr_start is ignored. Then replay segnum 2 with txid=redundancy → free_slots=1, wr_ready=1.
- rd_start segnum=9 never captured → rd_miss pulse at cycle 2, no rd_valid. Replay of a slot still in W_FILL → rd_miss.
- SEG_BYTES_MAX=8, capture 12 words → single err_trunc pulse. Replay returns exactly 8 words, with rd_last on word 7.
- Capture segnum=7 twice with different data → free_slots shows one slot used. Replay returns the second data set.
- rstn low for 1 cycle mid-replay → rd_valid=0 the next cycle, free_slots=NUM_SLOTS. Subsequent replay of any tag → rd_miss.
